// File: rtl/note_pkg.sv
`default_nettype none
// =============================================================================
// note_pkg: shared lane, scheduler-state and LFSR definitions.   Rev 1.0
// =============================================================================
package note_pkg;

  localparam int NUM_LANES = 5;

  typedef enum logic [2:0] {
    LANE_GREEN  = 3'd0,
    LANE_RED    = 3'd1,
    LANE_YELLOW = 3'd2,
    LANE_BLUE   = 3'd3,
    LANE_ORANGE = 3'd4
  } lane_e;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_GAP  = 2'd1,
    ST_PICK = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_FALLBACK = 16'h0001;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_spawn_scheduler_lfsr16.sv
`default_nettype none
// =============================================================================
// lfsr16: 16-bit Fibonacci LFSR, advanced on request, zero seed remapped.  Rev 1.0
// =============================================================================
module lfsr16 (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_advance,
  input  logic [15:0] i_seed,
  output logic [15:0] o_value
);
  import note_pkg::*;

  logic [15:0] r_lfsr;
  logic [15:0] w_seed;

  // An all-zero state would lock up the register.
  assign w_seed = (i_seed == 16'h0000) ? LFSR_FALLBACK : i_seed;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lfsr <= w_seed;
    end else if (i_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/note_spawn_scheduler.sv
`default_nettype none
// =============================================================================
// note_spawn_scheduler: picks an idle fret lane each frame and holds a spawn
// request until that lane's sprite starts moving.                     Rev 1.0
// =============================================================================
module note_spawn_scheduler #(
  parameter logic [15:0] SEED        = 16'h0001,
  parameter logic [9:0]  GAP_FRAMES  = 10'd20,
  parameter logic [4:0]  DENSITY     = 5'd8,
  parameter logic [1:0]  HOLD_FRAMES = 2'd2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_frame_clk,
  input  logic        i_enable,
  input  logic [4:0]  i_lane_idle,
  output logic [4:0]  o_spawn,
  output logic        o_busy,
  output logic [15:0] o_note_count,
  output logic [7:0]  o_miss_count
);
  import note_pkg::*;

  sched_state_t r_state;
  logic         r_fc_sync;
  logic         r_fc_prev;
  logic         r_fe;
  logic [9:0]   r_gap_cnt;
  logic [1:0]   r_hold_cnt;
  logic [2:0]   r_lane;
  logic [4:0]   r_spawn;
  logic [15:0]  r_note_count;
  logic [7:0]   r_miss_count;

  logic [15:0]  w_lfsr;
  logic         w_advance;
  logic         w_hit;
  logic [2:0]   w_cand;
  logic         w_found;
  logic [2:0]   w_pick;
  logic [3:0]   w_sum;
  logic [2:0]   w_idx;
  logic         w_ack;
  logic         w_hold_done;

  // Frame edge: one sync stage then rise detect, two Clk after frame_clk rises.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc_sync <= 1'b0;
      r_fc_prev <= 1'b0;
      r_fe      <= 1'b0;
    end else begin
      r_fc_sync <= i_frame_clk;
      r_fc_prev <= r_fc_sync;
      r_fe      <= r_fc_sync & ~r_fc_prev;
    end
  end

  assign w_advance = i_enable && (r_state == ST_PICK) && r_fe;

  lfsr16 u_lfsr (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_advance (w_advance),
    .i_seed    (SEED),
    .o_value   (w_lfsr)
  );

  assign w_hit  = ({1'b0, w_lfsr[7:4]} < DENSITY);
  assign w_cand = (w_lfsr[2:0] >= 3'd5) ? (w_lfsr[2:0] - 3'd5) : w_lfsr[2:0];

  // Walk downward so the nearest idle lane after the candidate wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    w_sum   = 4'd0;
    w_idx   = 3'd0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_cand} + 4'(k);
      w_idx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
      if (i_lane_idle[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_ack       = ~i_lane_idle[r_lane];
  assign w_hold_done = (({1'b0, r_hold_cnt} + 3'd1) >= {1'b0, HOLD_FRAMES});

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_OFF;
      r_gap_cnt    <= 10'd0;
      r_hold_cnt   <= 2'd0;
      r_lane       <= 3'd0;
      r_spawn      <= 5'd0;
      r_note_count <= 16'd0;
      r_miss_count <= 8'd0;
    end else if (!i_enable) begin
      r_state <= ST_OFF;
      r_spawn <= 5'd0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state   <= ST_GAP;
          r_gap_cnt <= GAP_FRAMES;
        end
        ST_GAP: begin
          if (r_fe) begin
            if (r_gap_cnt == 10'd0) r_state <= ST_PICK;
            else                    r_gap_cnt <= r_gap_cnt - 10'd1;
          end
        end
        ST_PICK: begin
          if (r_fe && w_hit && w_found) begin
            r_state    <= ST_HOLD;
            r_spawn    <= 5'd1 << w_pick;
            r_lane     <= w_pick;
            r_hold_cnt <= 2'd0;
          end
        end
        ST_HOLD: begin
          // Acknowledge beats a coincident timeout frame.
          if (w_ack) begin
            r_state      <= ST_GAP;
            r_spawn      <= 5'd0;
            r_gap_cnt    <= GAP_FRAMES;
            r_note_count <= r_note_count + 16'd1;
          end else if (r_fe) begin
            if (w_hold_done) begin
              r_state   <= ST_GAP;
              r_spawn   <= 5'd0;
              r_gap_cnt <= GAP_FRAMES;
              if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 2'd1;
            end
          end
        end
        default: r_state <= ST_OFF;
      endcase
    end
  end

  assign o_spawn      = r_spawn;
  assign o_busy       = (r_state == ST_HOLD);
  assign o_note_count = r_note_count;
  assign o_miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_note_spawn_scheduler.sv
`default_nettype none
// =============================================================================
// tb_note_spawn_scheduler: directed scenarios for note_spawn_scheduler. Rev 1.0
// =============================================================================
module tb_note_spawn_scheduler;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        enable;
  logic [4:0]  lane_idle;

  logic [4:0]  spawn,   spawn_d0,   spawn_ace;
  logic        busy,    busy_d0,    busy_ace;
  logic [15:0] notes,   notes_d0,   notes_ace;
  logic [7:0]  misses,  misses_d0,  misses_ace;

  int checks = 0;
  int errors = 0;

  note_spawn_scheduler #(
    .SEED(16'h0001), .GAP_FRAMES(10'd2), .DENSITY(5'd16), .HOLD_FRAMES(2'd2)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .i_frame_clk(frame_clk), .i_enable(enable),
    .i_lane_idle(lane_idle), .o_spawn(spawn), .o_busy(busy),
    .o_note_count(notes), .o_miss_count(misses)
  );

  note_spawn_scheduler #(
    .SEED(16'h0001), .GAP_FRAMES(10'd2), .DENSITY(5'd0), .HOLD_FRAMES(2'd2)
  ) u_dut_d0 (
    .Clk(Clk), .Reset(Reset), .i_frame_clk(frame_clk), .i_enable(enable),
    .i_lane_idle(lane_idle), .o_spawn(spawn_d0), .o_busy(busy_d0),
    .o_note_count(notes_d0), .o_miss_count(misses_d0)
  );

  note_spawn_scheduler #(
    .SEED(16'hACE1), .GAP_FRAMES(10'd2), .DENSITY(5'd8), .HOLD_FRAMES(2'd2)
  ) u_dut_ace (
    .Clk(Clk), .Reset(Reset), .i_frame_clk(frame_clk), .i_enable(enable),
    .i_lane_idle(lane_idle), .o_spawn(spawn_ace), .o_busy(busy_ace),
    .o_note_count(notes_ace), .o_miss_count(misses_ace)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Entered and left #1 after a rising edge; the frame edge is acted on by the third edge.
  task automatic tick();
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b0; lane_idle = 5'b11111; frame_clk = 1'b0;
    do_reset();
    checks++; if (spawn !== 5'd0)   begin errors++; $display("FAIL reset_spawn got %b want %b", spawn, 5'd0); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (notes !== 16'd0)  begin errors++; $display("FAIL reset_notes got %0d want 0", notes); end
    checks++; if (misses !== 8'd0)  begin errors++; $display("FAIL reset_misses got %0d want 0", misses); end
  endtask

  task automatic test_basic_grant();
    enable = 1'b1;
    repeat (3) tick();
    checks++; if (spawn !== 5'd0) begin errors++; $display("FAIL basic_early got %b want %b", spawn, 5'd0); end
    tick();
    checks++; if (spawn !== 5'b00010) begin errors++; $display("FAIL basic_spawn got %b want %b", spawn, 5'b00010); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    lane_idle = 5'b11101;
    @(posedge Clk); #1;
    checks++; if (spawn !== 5'd0)  begin errors++; $display("FAIL basic_ack_spawn got %b want %b", spawn, 5'd0); end
    checks++; if (notes !== 16'd1) begin errors++; $display("FAIL basic_ack_notes got %0d want 1", notes); end
    lane_idle = 5'b11111;
  endtask

  task automatic test_second_grant();
    repeat (3) tick();
    checks++; if (spawn !== 5'd0) begin errors++; $display("FAIL second_early got %b want %b", spawn, 5'd0); end
    tick();
    checks++; if (spawn !== 5'b00100) begin errors++; $display("FAIL second_spawn got %b want %b", spawn, 5'b00100); end
    lane_idle = 5'b11011;
    @(posedge Clk); #1;
    checks++; if (notes !== 16'd2) begin errors++; $display("FAIL second_notes got %0d want 2", notes); end
    lane_idle = 5'b11111;
  endtask

  task automatic test_round_robin();
    lane_idle = 5'b11101;
    do_reset();
    repeat (4) tick();
    checks++; if (spawn !== 5'b00100) begin errors++; $display("FAIL rr_spawn got %b want %b", spawn, 5'b00100); end
    lane_idle = 5'b11001;
    @(posedge Clk); #1;
    checks++; if (notes !== 16'd1) begin errors++; $display("FAIL rr_notes got %0d want 1", notes); end
    lane_idle = 5'b00000;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (spawn !== 5'd0 || busy !== 1'b0) begin
        errors++; $display("FAIL rr_none_idle frame %0d got spawn=%b busy=%b want 00000/0", i, spawn, busy);
      end
    end
    lane_idle = 5'b11111;
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (4) tick();
    checks++; if (spawn !== 5'b00010) begin errors++; $display("FAIL to_spawn got %b want %b", spawn, 5'b00010); end
    tick();
    checks++; if (spawn !== 5'b00010 || busy !== 1'b1) begin errors++; $display("FAIL to_held got %b/%b want 00010/1", spawn, busy); end
    tick();
    checks++; if (spawn !== 5'd0)   begin errors++; $display("FAIL to_drop got %b want %b", spawn, 5'd0); end
    checks++; if (misses !== 8'd1)  begin errors++; $display("FAIL to_misses got %0d want 1", misses); end
    checks++; if (notes !== 16'd0)  begin errors++; $display("FAIL to_notes got %0d want 0", notes); end
  endtask

  task automatic test_tie();
    repeat (4) tick();
    checks++; if (spawn !== 5'b00100) begin errors++; $display("FAIL tie_spawn got %b want %b", spawn, 5'b00100); end
    tick();
    // Acknowledge lands in the same cycle as the second hold frame edge.
    frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    #1 lane_idle = 5'b11011;
    @(posedge Clk); #1;
    checks++; if (spawn !== 5'd0)   begin errors++; $display("FAIL tie_drop got %b want %b", spawn, 5'd0); end
    checks++; if (notes !== 16'd1)  begin errors++; $display("FAIL tie_notes got %0d want 1", notes); end
    checks++; if (misses !== 8'd1)  begin errors++; $display("FAIL tie_misses got %0d want 1", misses); end
    frame_clk = 1'b0; lane_idle = 5'b11111;
    repeat (2) @(posedge Clk); #1;
  endtask

  task automatic test_disable();
    repeat (4) tick();
    checks++; if (spawn !== 5'b10000) begin errors++; $display("FAIL dis_spawn got %b want %b", spawn, 5'b10000); end
    enable = 1'b0; lane_idle = 5'b01111;
    @(posedge Clk); #1;
    checks++; if (spawn !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL dis_off got %b/%b want 00000/0", spawn, busy); end
    checks++; if (notes !== 16'd1 || misses !== 8'd1) begin errors++; $display("FAIL dis_counts got %0d/%0d want 1/1", notes, misses); end
    lane_idle = 5'b11111;
    repeat (3) @(posedge Clk); #1;
    enable = 1'b1;
    repeat (4) tick();
    checks++; if (spawn !== 5'b00001) begin errors++; $display("FAIL dis_resume got %b want %b", spawn, 5'b00001); end
    lane_idle = 5'b11110;
    @(posedge Clk); #1;
    checks++; if (notes !== 16'd2) begin errors++; $display("FAIL dis_resume_notes got %0d want 2", notes); end
    lane_idle = 5'b11111;
  endtask

  task automatic test_reset_mid_gap();
    tick();
    Reset = 1'b1;
    @(posedge Clk); #1;
    checks++; if (spawn !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_gap_out got %b/%b want 00000/0", spawn, busy); end
    checks++; if (notes !== 16'd0 || misses !== 8'd0) begin errors++; $display("FAIL rst_gap_counts got %0d/%0d want 0/0", notes, misses); end
    Reset = 1'b0;
  endtask

  task automatic test_density();
    lane_idle = 5'b11111;
    do_reset();
    for (int f = 1; f <= 100; f++) begin
      tick();
      checks++; if (spawn_d0 !== 5'd0 || busy_d0 !== 1'b0) begin
        errors++; $display("FAIL d0_spawn frame %0d got %b/%b want 00000/0", f, spawn_d0, busy_d0);
      end
      if (f == 4) begin
        checks++; if (spawn_ace !== 5'd0) begin errors++; $display("FAIL ace_skip got %b want %b", spawn_ace, 5'd0); end
      end
      if (f == 7) begin
        checks++; if (spawn_ace !== 5'b00100) begin errors++; $display("FAIL ace_grant got %b want %b", spawn_ace, 5'b00100); end
      end
    end
    checks++; if (notes_d0 !== 16'd0 || misses_d0 !== 8'd0) begin errors++; $display("FAIL d0_counts got %0d/%0d want 0/0", notes_d0, misses_d0); end
  endtask

  initial begin
    Reset = 1'b1; enable = 1'b0; frame_clk = 1'b0; lane_idle = 5'b11111;
    test_reset();
    test_basic_grant();
    test_second_grant();
    test_round_robin();
    test_timeout();
    test_tie();
    test_disable();
    test_reset_mid_gap();
    test_density();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/note_spawn_scheduler.md
Name: note_spawn_scheduler

Overview:
- Decides when and in which lane a new falling note sprite is launched, for the five fret lanes (0 green, 1 red, 2 yellow, 3 blue, 4 orange).
- Uses a per-frame LFSR, a density threshold, a minimum inter-note frame gap and a round-robin fallback to choose an idle lane.
- Drives a level-held spawn request to the chosen lane's sprite, which consumes it as its rng input, and waits for that sprite to report motion.
- Sits between the game-state controller (enable) and the five lane sprite blocks.

Parameters:
- SEED, 16'h0001: LFSR reset value. A value of 0 is replaced by 16'h0001.
- GAP_FRAMES, 10'd20: frame edges to wait after a grant resolves before the next pick.
- DENSITY, 5'd8: spawn attempt succeeds when lfsr[7:4] < DENSITY. 0 means never spawn; 16 means always spawn.
- HOLD_FRAMES, 2'd2: frame edges a request may go unacknowledged before it is dropped.

Ports:
- Clk, in, 1: 50 MHz system clock.
- Reset, in, 1: synchronous, active-high.
- frame_clk, in, 1: ~60 Hz frame strobe.
- enable, in, 1: gameplay running.
- lane_idle, in, 5: bit i high when lane i's sprite is parked (Y motion == 0).
- spawn, out, 5: one-hot level request; bit i feeds lane i's rng input.
- busy, out, 1: high in state HOLD.
- note_count, out, 16: count of acknowledged spawns; wraps.
- miss_count, out, 8: count of timed-out requests; saturates at 255.

Behaviour:
- fe: a one-Clk pulse, registered as frame_clk high AND previous frame_clk low. This gives 2 cycles of latency from the frame_clk rise.
- Reset values:
  - state = OFF, spawn = 0, busy = 0.
  - lfsr = SEED, gap_cnt = 0, hold_cnt = 0.
  - note_count = 0, miss_count = 0.
- LFSR:
  - Fibonacci, fb = l[15]^l[13]^l[12]^l[10], next = {l[14:0], fb}.
  - Advances only on fe while in PICK, after that cycle's decision. Each decision therefore uses the pre-advance value.
- OFF:
  - spawn = 0.
  - When enable = 1, go to GAP next cycle with gap_cnt = GAP_FRAMES.
- GAP:
  - On fe: if gap_cnt == 0, go to PICK; else decrement gap_cnt.
  - PICK is therefore entered on the (GAP_FRAMES+1)th fe.
- PICK, on fe:
  - If lfsr[7:4] >= DENSITY, stay in PICK (skip this frame).
  - Otherwise cand = lfsr[2:0], minus 5 if >= 5.
  - If lane_idle[cand], choose cand. Otherwise search cand+1, cand+2, ... modulo 5 and take the first idle lane.
  - If no lane is idle, stay in PICK.
  - If a lane is chosen, go to HOLD next cycle: spawn = one-hot(lane), hold_cnt = 0, lane registered.
- HOLD:
  - spawn is held constant.
  - Acknowledge: on any cycle with lane_idle[lane] == 0, next cycle spawn = 0, note_count += 1, gap_cnt = GAP_FRAMES, go to GAP.
  - Timeout: on fe without acknowledge, hold_cnt += 1. When it reaches HOLD_FRAMES, next cycle spawn = 0, miss_count += 1 (saturating), gap_cnt = GAP_FRAMES, go to GAP.
  - If acknowledge and the timeout fe coincide, acknowledge wins.
- enable = 0 in any state:
  - Next cycle go to OFF, spawn = 0.
  - A pending HOLD is abandoned without changing either counter. Disable takes priority over an acknowledge in the same cycle.
  - lfsr and counters are retained.
- Reset mid-HOLD: spawn drops on the next edge and all state returns to reset values.
- Exactly one spawn bit is ever high. spawn never changes while in HOLD.

Decomposition:
- Package note_pkg:
  - NUM_LANES = 5.
  - Lane enum LANE_GREEN..LANE_ORANGE = 0..4.
  - sched_state_t {OFF, GAP, PICK, HOLD}.
  - LFSR tap constants.
- Sub-module lfsr16 (Clk, Reset, advance, seed → value) holds the shift register.
- The scheduler FSM, edge detector, round-robin search and counters stay in note_spawn_scheduler.

Test Plan:
- Basic grant. Setup: SEED = 1, DENSITY = 16, GAP_FRAMES = 2, all lanes idle. Stimulus: raise enable. Required:
  - spawn = 5'b00010 the cycle after the 4th fe.
  - busy = 1.
  - Lane 1 dropping lane_idle gives note_count = 1 and spawn = 0 next cycle.
- Second grant. Continuing from the basic-grant case, required:
  - The next decision uses lfsr = 16'h0002 and grants spawn = 5'b00100 (lane 2).
  - The grant comes 4 fe after the acknowledge.
- Round-robin fallback. Setup: SEED = 1, lane_idle = 5'b11101 (lane 1 busy). Required: spawn = 5'b00100. With lane_idle = 5'b00000, the block stays in PICK with spawn = 0 across 10 fe.
- Density limits. DENSITY = 0: no spawn for 100 fe. SEED = 16'hACE1 with DENSITY = 8: the first PICK fe skips, since lfsr[7:4] = 14.
- Timeout and tie-break. HOLD_FRAMES = 2 with no acknowledge: spawn drops after the 2nd fe, miss_count = 1, note_count unchanged. Acknowledge on the same cycle as the 2nd fe: note_count += 1, miss_count unchanged.
- Disable and reset. enable low during HOLD: spawn = 0 next cycle, counters unchanged, state OFF. Reset asserted mid-GAP: all outputs return to reset values on the next edge.
